snoop_bus_ctrl: RTL

Sequencer for the shared snoop bus and the single-ported main memory between the per-core cache controllers. Each cache raises a miss or write-back request; this block picks one requester round-robin, broadcasts the miss on the snoop bus, and collects a dirty owner's flush. It then performs the required memory read or write and returns the line to the requester with a one-cycle ack. The block serialises all coherence and memory traffic, so at most one bus transaction is in flight at a time.

---
 rtl/snoop_bus_ctrl_pkg.sv | 19 +
 rtl/snoop_bus_ctrl_if.sv | 21 ++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 22 ++
 rtl/snoop_bus_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// snoop_bus_ctrl_pkg: shared bus messages, op codes, error codes and FSM states
package snoop_bus_ctrl_pkg;
  localparam int BLOCKADDRBIT = 8;
  localparam int WORDSIZE = 8;
  localparam int BLOCKBYTE = 4;
  localparam int LINEW = WORDSIZE * BLOCKBYTE;
  localparam int ERRWIDTH = 2;
  localparam logic [3:0] MSG_NOTHING = 4'd0;
  localparam logic [3:0] MSG_READMISS = 4'd1;
  localparam logic [3:0] MSG_WRITEMISS = 4'd2;
  localparam logic [3:0] I_HAVE_DATA = 4'd3;
  localparam logic RD = 1'b0;
  localparam logic WT = 1'b1;
  localparam logic [ERRWIDTH-1:0] NOERR = 2'd0;
  localparam logic [ERRWIDTH-1:0] BUS_ACTION_ERR = 2'd1;
  localparam logic [ERRWIDTH-1:0] ERR_MEM_TIMEOUT = 2'd2;
  typedef enum logic [1:0] {OP_RDMISS = 2'd0, OP_WRMISS = 2'd1, OP_WB = 2'd2, OP_RSVD = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, MEM_RD, MEM_WR, DONE, ERROR} state_e;
endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// snoop_bus_ctrl_if: request, snoop and memory signals between the sequencer and its caches/memory
interface snoop_bus_ctrl_if import snoop_bus_ctrl_pkg::*; #(parameter int NREQ = 2);
  logic [NREQ-1:0] req, gnt, ack;
  logic [2*NREQ-1:0] reqOp;
  logic [NREQ*BLOCKADDRBIT-1:0] reqAddr;
  logic [NREQ*LINEW-1:0] reqData, snoopInValue;
  logic [4*NREQ-1:0] snoopInAction;
  logic [LINEW-1:0] respData, memDataOut, memDataIn;
  logic [3:0] snoopOutAction;
  logic [BLOCKADDRBIT-1:0] snoopOutAddr, memBlockAddr;
  logic memReq, memRW, memAvailable;
  logic [ERRWIDTH-1:0] errFlag;
  modport master (
    input req, reqOp, reqAddr, reqData, snoopInAction, snoopInValue, memDataIn, memAvailable,
    output gnt, ack, respData, snoopOutAction, snoopOutAddr, memReq, memRW, memBlockAddr, memDataOut, errFlag
  );
  modport slave (
    output req, reqOp, reqAddr, reqData, snoopInAction, snoopInValue, memDataIn, memAvailable,
    input gnt, ack, respData, snoopOutAction, snoopOutAddr, memReq, memRW, memBlockAddr, memDataOut, errFlag
  );
endinterface

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot pick of the first requester at or after the pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);
  int k;
  always_comb begin
    win = '0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k[PW-1:0]]) begin
        win = '0;
        win[k[PW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin sequencer for the shared snoop bus and single-ported memory
module snoop_bus_ctrl import snoop_bus_ctrl_pkg::*; #(
  parameter int NREQ = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  snoop_bus_ctrl_if.master bus
);
  localparam int PW = $clog2(NREQ);
  state_e state;
  logic [PW-1:0] ptr, gidx, widx;
  logic [NREQ-1:0] win;
  logic [BLOCKADDRBIT-1:0] addr, waddr;
  logic [LINEW-1:0] wdata, hval;
  logic [7:0] tmo;
  logic [2:0] hits;
  logic [1:0] wop;
  logic go_err;
  logic [ERRWIDTH-1:0] err_code;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req), .ptr(ptr), .win(win));
  always_comb begin
    widx = '0;
    for (int i = 0; i < NREQ; i++) if (win[i]) widx = PW'(i);
    wop = bus.reqOp[2*widx +: 2];
    waddr = bus.reqAddr[widx*BLOCKADDRBIT +: BLOCKADDRBIT];
    wdata = bus.reqData[widx*LINEW +: LINEW];
  end
  // the granted cache's own snoop answer never counts as an owner
  always_comb begin
    hits = '0;
    hval = '0;
    for (int i = 0; i < NREQ; i++)
      if (PW'(i) != gidx && bus.snoopInAction[4*i +: 4] == I_HAVE_DATA) begin
        hits = hits + 3'd1;
        hval = bus.snoopInValue[i*LINEW +: LINEW];
      end
  end
  always_comb begin
    go_err = (state == IDLE && |bus.req && wop == OP_RSVD) || (state == SNOOP && hits > 3'd1) ||
             ((state == MEM_RD || state == MEM_WR) && !bus.memAvailable && tmo == 8'(MEM_TIMEOUT - 1));
    err_code = (state == MEM_RD || state == MEM_WR) ? ERR_MEM_TIMEOUT : BUS_ACTION_ERR;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      addr <= '0;
      tmo <= '0;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.respData <= '0;
      bus.snoopOutAction <= MSG_NOTHING;
      bus.snoopOutAddr <= '0;
      bus.memReq <= 1'b0;
      bus.memRW <= RD;
      bus.memBlockAddr <= '0;
      bus.memDataOut <= '0;
      bus.errFlag <= NOERR;
    end else begin
      case (state)
        IDLE: begin
          tmo <= '0;
          if (|bus.req) begin
            gidx <= widx;
            bus.gnt <= win;
            addr <= waddr;
            if (wop == OP_WB) begin
              state <= MEM_WR;
              bus.memReq <= 1'b1;
              bus.memRW <= WT;
              bus.memBlockAddr <= waddr;
              bus.memDataOut <= wdata;
              bus.respData <= '0;
            end else begin
              state <= BCAST;
              bus.snoopOutAction <= (wop == OP_RDMISS) ? MSG_READMISS : MSG_WRITEMISS;
              bus.snoopOutAddr <= waddr;
            end
          end
        end
        BCAST: begin
          bus.snoopOutAction <= MSG_NOTHING;
          bus.snoopOutAddr <= '0;
          state <= SNOOP;
        end
        SNOOP: begin
          bus.memReq <= 1'b1;
          bus.memBlockAddr <= addr;
          bus.memRW <= (hits == 3'd1) ? WT : RD;
          bus.memDataOut <= (hits == 3'd1) ? hval : '0;
          bus.respData <= (hits == 3'd1) ? hval : '0;
          state <= (hits == 3'd1) ? MEM_WR : MEM_RD;
        end
        MEM_RD, MEM_WR: begin
          if (bus.memAvailable) begin
            bus.memReq <= 1'b0;
            bus.memRW <= RD;
            bus.memBlockAddr <= '0;
            bus.memDataOut <= '0;
            bus.ack <= bus.gnt;
            if (state == MEM_RD) bus.respData <= bus.memDataIn;
            state <= DONE;
          end else tmo <= tmo + 8'd1;
        end
        DONE: begin
          bus.ack <= '0;
          bus.gnt <= '0;
          bus.respData <= '0;
          ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
      // any fault parks the block with every output at its idle value except errFlag
      if (go_err) begin
        state <= ERROR;
        bus.errFlag <= err_code;
        bus.gnt <= '0;
        bus.ack <= '0;
        bus.respData <= '0;
        bus.snoopOutAction <= MSG_NOTHING;
        bus.snoopOutAddr <= '0;
        bus.memReq <= 1'b0;
        bus.memRW <= RD;
        bus.memBlockAddr <= '0;
        bus.memDataOut <= '0;
      end
    end
  end
endmodule
